// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU sitting between issue and writeback.
//   Simple ops (logic, add/sub, compares, shifts) are registered on the
//   accept edge. MUL/MULHU/DIVU/REMU run an iterative shift-add /
//   restoring-divide engine that takes WIDTH edges.
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   in_valid / in_ready   upstream handshake for a, b, alu_control
//   a, b                  operands (shifts use b[SHW-1:0])
//   alu_control           4-bit op select
//   out_valid / out_ready downstream handshake for result/zero/ovf
//   result, zero, ovf     registered result, (result==0), signed overflow
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000, OP_OR    = 4'b0001, OP_ADD  = 4'b0010,
        OP_XOR   = 4'b0011, OP_SLL   = 4'b0100, OP_SRL  = 4'b0101,
        OP_SUB   = 4'b0110, OP_SLTU  = 4'b0111, OP_SLT  = 4'b1000,
        OP_SRA   = 4'b1001, OP_MUL   = 4'b1010, OP_MULHU = 4'b1011,
        OP_NOR   = 4'b1100, OP_DIVU  = 4'b1101, OP_REMU = 4'b1110,
        OP_NONE  = 4'b1111
    } op_e;

    state_e           state, state_nxt;
    op_e              op_in, op_q;
    logic             accept, in_iter, in_div, q_div;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo, opnd;
    logic [WIDTH-1:0] hi_nxt, lo_nxt, iter_res;
    logic [WIDTH-1:0] simple_res, sum, diff;
    logic             simple_ovf;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, ovf_q;

    assign op_in   = op_e'(alu_control);
    assign in_iter = (op_in == OP_MUL) || (op_in == OP_MULHU) ||
                     (op_in == OP_DIVU) || (op_in == OP_REMU);
    assign in_div  = (op_in == OP_DIVU) || (op_in == OP_REMU);
    assign q_div   = (op_q == OP_DIVU) || (op_q == OP_REMU);
    assign accept  = in_valid && in_ready;

    assign result = result_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;

    // Single-cycle datapath
    always_comb begin
        sum        = a + b;
        diff       = a - b;
        shamt      = b[SHW-1:0];
        simple_res = '0;
        simple_ovf = 1'b0;
        case (op_in)
            OP_AND:  simple_res = a & b;
            OP_OR:   simple_res = a | b;
            OP_XOR:  simple_res = a ^ b;
            OP_NOR:  simple_res = ~(a | b);
            OP_ADD: begin
                simple_res = sum;
                simple_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                simple_res = diff;
                simple_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  simple_res = a << shamt;
            OP_SRL:  simple_res = a >> shamt;
            OP_SRA:  simple_res = WIDTH'($signed(a) >>> shamt);
            default: simple_res = '0;
        endcase
    end

    // Iterative engine step. Multiply: {hi,lo} is a right-shifting
    // accumulator with the multiplier in lo. Divide: lo shifts the dividend
    // out at the top and the quotient in at the bottom, hi is the partial
    // remainder. A zero divisor always "succeeds", giving all-ones / a.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_shift = {hi, lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        hi_nxt    = mul_sum[WIDTH:1];
        lo_nxt    = {mul_sum[0], lo[WIDTH-1:1]};
        if (q_div) begin
            if (!div_diff[WIDTH]) begin
                hi_nxt = div_diff[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = div_shift[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b0};
            end
        end
        iter_res = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? lo_nxt : hi_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) state_nxt = in_iter ? BUSY : DONE;
            end
            BUSY: begin
                if (cnt == CW'(1)) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_nxt = accept ? (in_iter ? BUSY : DONE) : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            op_q     <= OP_AND;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            op_q <= op_in;
            if (in_iter) begin
                cnt  <= CW'(WIDTH);
                hi   <= '0;
                lo   <= in_div ? a : b;
                opnd <= in_div ? b : a;
            end else begin
                result_q <= simple_res;
                zero_q   <= (simple_res == '0);
                ovf_q    <= simple_ovf;
            end
        end else if (state == BUSY) begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                result_q <= iter_res;
                zero_q   <= (iter_res == '0);
                ovf_q    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed, table-driven bench for alu_pipe (WIDTH=32) plus
// hand-written sequences for reset, back-pressure, streaming and operand
// latching.
module tb_alu_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] a, b;
    logic [3:0]  alu_control;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        zero, ovf;

    int n_cmp = 0;
    int n_bad = 0;

    alu_pipe #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_control(alu_control),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        int unsigned edges;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] va,
                                input logic [31:0] vb, input logic [31:0] res,
                                input logic vo, input int unsigned ed);
        vec_t v;
        v.op = op; v.a = va; v.b = vb; v.res = res; v.ovf = vo; v.edges = ed;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle and out_ready=1.
    task automatic run_vec(input vec_t v, input int idx);
        int unsigned e;
        in_valid = 1'b1; alu_control = v.op; a = v.a; b = v.b; out_ready = 1'b1;
        check($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; alu_control = 4'($urandom);
        e = 0;
        while (!out_valid && e < 200) begin
            @(posedge clk); #1;
            e++;
        end
        check($sformatf("v%0d_edges", idx), e, v.edges);
        check($sformatf("v%0d_res", idx), result, v.res);
        check($sformatf("v%0d_ovf", idx), 32'(ovf), 32'(v.ovf));
        check($sformatf("v%0d_zero", idx), 32'(zero), 32'(v.res == 32'd0));
        @(posedge clk); #1;
        check($sformatf("v%0d_release", idx), 32'(out_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] s_a[4], s_b[4], s_exp[4];

    initial begin
        int unsigned e;
        logic stale;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; alu_control = '0;

        // op, a, b, expected result, expected ovf, edges from accept to out_valid
        vt.push_back(mk(4'b0010, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1, 0));
        vt.push_back(mk(4'b0110, 32'h5,        32'h5,        32'h0,        1'b0, 0));
        vt.push_back(mk(4'b0111, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 0));
        vt.push_back(mk(4'b1000, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 0));
        vt.push_back(mk(4'b1001, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 0));
        vt.push_back(mk(4'b0101, 32'h80000000, 32'd31,       32'h1,        1'b0, 0));
        vt.push_back(mk(4'b0100, 32'h1,        32'h25,       32'h20,       1'b0, 0));
        vt.push_back(mk(4'b1001, 32'h12345678, 32'h20,       32'h12345678, 1'b0, 0));
        vt.push_back(mk(4'b0000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 0));
        vt.push_back(mk(4'b0011, 32'h000000FF, 32'h0000000F, 32'h000000F0, 1'b0, 0));
        vt.push_back(mk(4'b1100, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 0));
        vt.push_back(mk(4'b0110, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1, 0));
        vt.push_back(mk(4'b0010, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 0));
        vt.push_back(mk(4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h0,        1'b0, 0));
        vt.push_back(mk(4'b1010, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE, 1'b0, 32));
        vt.push_back(mk(4'b1011, 32'hFFFFFFFF, 32'h2,        32'h1,        1'b0, 32));
        vt.push_back(mk(4'b1010, 32'h7,        32'h9,        32'h3F,       1'b0, 32));
        vt.push_back(mk(4'b1011, 32'h80000000, 32'h4,        32'h2,        1'b0, 32));
        vt.push_back(mk(4'b1101, 32'd100,      32'd7,        32'd14,       1'b0, 32));
        vt.push_back(mk(4'b1110, 32'd100,      32'd7,        32'd2,        1'b0, 32));
        vt.push_back(mk(4'b1101, 32'd9,        32'd0,        32'hFFFFFFFF, 1'b0, 32));
        vt.push_back(mk(4'b1110, 32'd9,        32'd0,        32'd9,        1'b0, 32));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a multiply
        in_valid = 1'b1; alu_control = 4'b1010; a = 32'd7; b = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_result", result, 32'd0);
        check("mr_zero", 32'(zero), 32'd1);
        check("mr_in_ready", 32'(in_ready), 32'd1);
        #2 reset = 1'b0;
        stale = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        check("mr_no_stale", 32'(stale), 32'd0);

        // Table of single operations
        foreach (vt[i]) run_vec(vt[i], i);

        // Back-pressure: hold result, then back-to-back accept on release
        out_ready = 1'b0; in_valid = 1'b1; alu_control = 4'b0010; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'h1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("bp%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_res", k), result, 32'd7);
            check($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1; in_valid = 1'b1; alu_control = 4'b0001; a = 32'hF0; b = 32'h0F;
        #1;
        check("bp_in_ready_release", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_res", result, 32'hFF);
        @(posedge clk); #1;

        // Continuous stream of ADDs
        s_a[0] = 32'd1;        s_b[0] = 32'd2;   s_exp[0] = 32'd3;
        s_a[1] = 32'd10;       s_b[1] = 32'd20;  s_exp[1] = 32'd30;
        s_a[2] = 32'hFFFFFFFF; s_b[2] = 32'd2;   s_exp[2] = 32'd1;
        s_a[3] = 32'd100;      s_b[3] = 32'd200; s_exp[3] = 32'd300;
        out_ready = 1'b1; in_valid = 1'b1; alu_control = 4'b0010; a = s_a[0]; b = s_b[0];
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("st%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("st%0d_res", k), result, s_exp[k]);
            if (k < 3) begin
                a = s_a[k+1]; b = s_b[k+1];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        check("st_idle", 32'(out_valid), 32'd0);

        // Operand changes during a busy DIVU are ignored
        out_ready = 1'b0; in_valid = 1'b1; alu_control = 4'b1101; a = 32'd1000; b = 32'd10;
        @(posedge clk); #1;
        e = 0;
        while (!out_valid && e < 200) begin
            in_valid = 1'b1; a = $urandom; b = $urandom; alu_control = 4'($urandom);
            check($sformatf("dv%0d_in_ready", e), 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            e++;
        end
        in_valid = 1'b0;
        check("dv_edges", e, 32'd32);
        check("dv_res", result, 32'd100);
        check("dv_zero", 32'(zero), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("dv_release", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
